// File: rtl/fractal_pkg.sv
// Shared definitions for the fractal view controller: coordinate format,
// screen geometry, default view parameters, button bit indices and the
// frame-update state encoding.
package fractal_pkg;

  localparam int COORD_W = 24;
  localparam int FRAC_W  = 20;

  typedef logic signed [COORD_W-1:0] coord_t;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam int BASE_STEP = 4915;       // ~3.0/640 in Q4.20
  localparam int CLAMP     = 2097152;    // 2.0 in Q4.20
  localparam int ZOOM_MAX  = 8;
  localparam int PAN_SHIFT = 3;

  localparam int CENTER_RE_RST = -524288; // -0.5 in Q4.20

  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_LEFT = 2;
  localparam int BTN_RGHT = 3;
  localparam int BTN_ZIN  = 4;
  localparam int BTN_ZOUT = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    ORIGIN = 2'd2
  } view_state_t;

endpackage

// File: rtl/coord_sat_add.sv
// Signed add/subtract of two coordinates with symmetric saturation.
// Ports:
//   i_a, i_b : signed operands
//   i_sub    : 1 = i_a - i_b, 0 = i_a + i_b
//   o_sum    : result clamped to [-LIM, +LIM]
module coord_sat_add import fractal_pkg::*; #(
  parameter int W   = fractal_pkg::COORD_W,
  parameter int LIM = fractal_pkg::CLAMP
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  input  logic                i_sub,
  output logic signed [W-1:0] o_sum
);

  localparam logic signed [W:0] LIM_P = (W+1)'(LIM);
  localparam logic signed [W:0] LIM_N = -LIM_P;

  logic signed [W:0] w_a;
  logic signed [W:0] w_b;
  logic signed [W:0] w_full;

  // One guard bit is enough: both operands are bounded well inside the range.
  assign w_a    = {i_a[W-1], i_a};
  assign w_b    = {i_b[W-1], i_b};
  assign w_full = i_sub ? (w_a - w_b) : (w_a + w_b);

  always_comb begin
    o_sum = w_full[W-1:0];
    if (w_full > LIM_P) begin
      o_sum = LIM_P[W-1:0];
    end else if (w_full < LIM_N) begin
      o_sum = LIM_N[W-1:0];
    end
  end

endmodule

// File: rtl/fractal_view_ctrl.sv
// Frame-level view controller: samples pan/zoom buttons at frame start,
// keeps centre and zoom, derives origin/step, and walks the per-pixel
// complex coordinate in step with the VGA timing.
// Ports:
//   i_clk, i_rst_n         : clock, synchronous active-low reset
//   i_pix_ce               : pixel-clock enable
//   i_v_begin              : frame-start pulse (qualified by i_pix_ce)
//   i_pixel_x, i_pixel_y   : current pixel position
//   i_vga_active           : visible-area flag
//   i_btn                  : up/down/left/right/zoom_in/zoom_out levels
//   o_c_re, o_c_im         : coordinate of the pixel one pix_ce earlier
//   o_coord_valid          : o_c_re/o_c_im belong to a visible pixel
//   o_zoom                 : current zoom level
//   o_busy                 : frame update in progress
//
// state  | meaning
// IDLE   | waiting for frame start, pixel path running
// APPLY  | pan centre with old step, update zoom and step
// ORIGIN | recompute top-left origin from new centre and step
module fractal_view_ctrl import fractal_pkg::*; #(
  parameter int COORD_W   = fractal_pkg::COORD_W,
  parameter int BASE_STEP = fractal_pkg::BASE_STEP,
  parameter int ZOOM_MAX  = fractal_pkg::ZOOM_MAX,
  parameter int PAN_SHIFT = fractal_pkg::PAN_SHIFT,
  parameter int CLAMP     = fractal_pkg::CLAMP
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_pix_ce,
  input  logic                      i_v_begin,
  input  logic [9:0]                i_pixel_x,
  input  logic [9:0]                i_pixel_y,
  input  logic                      i_vga_active,
  input  logic [5:0]                i_btn,
  output logic signed [COORD_W-1:0] o_c_re,
  output logic signed [COORD_W-1:0] o_c_im,
  output logic                      o_coord_valid,
  output logic [3:0]                o_zoom,
  output logic                      o_busy
);

  localparam logic signed [COORD_W-1:0] RST_STEP = COORD_W'(BASE_STEP);
  localparam logic signed [COORD_W-1:0] RST_CRE  = COORD_W'(CENTER_RE_RST);
  localparam logic signed [COORD_W-1:0] RST_RE0  = COORD_W'(CENTER_RE_RST - 320 * BASE_STEP);
  localparam logic signed [COORD_W-1:0] RST_IM0  = COORD_W'(-240 * BASE_STEP);

  view_state_t r_state, w_state_next;

  logic [5:0]                r_btn;
  logic [3:0]                r_zoom, w_zoom_next;
  logic signed [COORD_W-1:0] r_step, w_step_next;
  logic signed [COORD_W-1:0] r_center_re, r_center_im;
  logic signed [COORD_W-1:0] w_center_re_next, w_center_im_next;
  logic signed [COORD_W-1:0] r_re0, r_im0;
  logic signed [COORD_W-1:0] r_c_re, r_c_im;
  logic                      r_valid;
  logic signed [COORD_W-1:0] w_pan, w_pan_re, w_pan_im;
  logic                      w_start;

  assign w_start = i_v_begin & i_pix_ce;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    o_busy       = 1'b1;
    case (r_state)
      IDLE: begin
        o_busy = 1'b0;
        if (w_start) w_state_next = APPLY;
      end
      APPLY:   w_state_next = ORIGIN;
      ORIGIN:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_zoom_next = r_zoom;
    if (r_btn[BTN_ZIN] && !r_btn[BTN_ZOUT] && r_zoom < 4'(ZOOM_MAX)) begin
      w_zoom_next = r_zoom + 4'd1;
    end else if (r_btn[BTN_ZOUT] && !r_btn[BTN_ZIN] && r_zoom != 4'd0) begin
      w_zoom_next = r_zoom - 4'd1;
    end
  end

  assign w_step_next = RST_STEP >>> w_zoom_next;

  // Pan is based on the step in force before this update's zoom change.
  assign w_pan    = r_step <<< PAN_SHIFT;
  assign w_pan_re = (r_btn[BTN_LEFT] ^ r_btn[BTN_RGHT]) ? w_pan : '0;
  assign w_pan_im = (r_btn[BTN_UP]   ^ r_btn[BTN_DOWN]) ? w_pan : '0;

  coord_sat_add #(.W(COORD_W), .LIM(CLAMP)) u_sat_re (
    .i_a   (r_center_re),
    .i_b   (w_pan_re),
    .i_sub (r_btn[BTN_LEFT]),
    .o_sum (w_center_re_next)
  );

  coord_sat_add #(.W(COORD_W), .LIM(CLAMP)) u_sat_im (
    .i_a   (r_center_im),
    .i_b   (w_pan_im),
    .i_sub (r_btn[BTN_UP]),
    .o_sum (w_center_im_next)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_btn       <= '0;
      r_zoom      <= '0;
      r_step      <= RST_STEP;
      r_center_re <= RST_CRE;
      r_center_im <= '0;
      r_re0       <= RST_RE0;
      r_im0       <= RST_IM0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) r_btn <= i_btn;
        end
        APPLY: begin
          r_center_re <= w_center_re_next;
          r_center_im <= w_center_im_next;
          r_zoom      <= w_zoom_next;
          r_step      <= w_step_next;
        end
        ORIGIN: begin
          // 320 = 256 + 64, 240 = 256 - 16
          r_re0 <= r_center_re - ((r_step <<< 8) + (r_step <<< 6));
          r_im0 <= r_center_im - ((r_step <<< 8) - (r_step <<< 4));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_c_re  <= '0;
      r_c_im  <= '0;
      r_valid <= 1'b0;
    end else if (i_pix_ce) begin
      r_valid <= i_vga_active;
      if (i_vga_active) begin
        if (i_pixel_x == 10'd0) begin
          r_c_re <= r_re0;
          r_c_im <= (i_pixel_y == 10'd0) ? r_im0 : (r_c_im + r_step);
        end else begin
          r_c_re <= r_c_re + r_step;
        end
      end
    end
  end

  assign o_c_re        = r_c_re;
  assign o_c_im        = r_c_im;
  assign o_coord_valid = r_valid;
  assign o_zoom        = r_zoom;

endmodule
